// File: rtl/execute_pkg.sv
// Shared pipeline types for the execute stage: op encodings, stage payloads,
// divider FSM encodings and the divider iteration counts.
package execute_pkg;

  typedef logic [4:0] creg_addr_t;

  typedef enum logic [5:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_LUI, ALU_AUIPC, ALU_JAL,
    ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
    ALU_LD, ALU_SD,
    ALU_MUL, ALU_MULW,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW
  } alu_op_t;

  typedef struct packed {
    alu_op_t op;
    logic    regwrite;
    logic    memread;
    logic    memwrite;
  } ctl_t;

  // srcb already carries the immediate for LD/SD/LUI/AUIPC
  typedef struct packed {
    ctl_t        ctl;
    logic [63:0] pc;
    logic [31:0] iresp_data;
    logic [63:0] srca;
    logic [63:0] srcb;
    logic [63:0] rd2;
    creg_addr_t  dst;
    logic        bubble;
    logic        valid;
    logic        ismem;
  } decode_data_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [63:0] pc;
    logic [31:0] iresp_data;
    logic [63:0] result;
    logic [63:0] rd2;
    creg_addr_t  dst;
    logic        bubble;
    logic        valid;
    logic        ismem;
  } excute_data_t;

  localparam int DIV_CYCLES  = 64;
  localparam int DIVW_CYCLES = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_div_op(input alu_op_t op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
                      ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
  endfunction

endpackage

// File: rtl/execute_divider.sv
// Iterative radix-2 restoring divider (IDLE -> BUSY -> DONE) for the execute
// stage; only built when MULDIV_EN is defined.
`ifdef MULDIV_EN
module divider
  import execute_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic        hold,
  input  logic        is_signed,
  input  logic        word,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  logic [1:0]  state;
  logic [6:0]  count;
  logic        word_q, qneg_q, rneg_q;
  logic [63:0] rem_q, quo_q, dvs_q;

  logic [63:0] a_ext, b_ext, a_mag, b_mag;
  logic        a_neg, b_neg;
  logic [64:0] partial, diff;
  logic        fits;
  logic [6:0]  last;
  logic [63:0] q_fix, r_fix;

  // Work on magnitudes; word operands are parked in the top half of the
  // quotient register so 32 shifts consume exactly the 32 dividend bits.
  always_comb begin
    a_ext = word ? (is_signed ? sext32(a[31:0]) : {32'b0, a[31:0]}) : a;
    b_ext = word ? (is_signed ? sext32(b[31:0]) : {32'b0, b[31:0]}) : b;
    a_neg = is_signed & a_ext[63];
    b_neg = is_signed & b_ext[63];
    a_mag = a_neg ? (64'd0 - a_ext) : a_ext;
    b_mag = b_neg ? (64'd0 - b_ext) : b_ext;
    partial = {rem_q, quo_q[63]};
    diff    = partial - {1'b0, dvs_q};
    fits    = ~diff[64];
    last    = word_q ? 7'(DIVW_CYCLES - 1) : 7'(DIV_CYCLES - 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= DIV_IDLE;
      count  <= '0;
      word_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (flush) begin
      state <= DIV_IDLE;
      count <= '0;
    end else if (!hold) begin
      case (state)
        DIV_IDLE: if (start) begin
          state  <= DIV_BUSY;
          count  <= '0;
          word_q <= word;
          qneg_q <= (a_neg ^ b_neg) & (b_mag != 64'd0);
          rneg_q <= a_neg;
          rem_q  <= '0;
          quo_q  <= word ? {a_mag[31:0], 32'b0} : a_mag;
          dvs_q  <= b_mag;
        end
        DIV_BUSY: begin
          rem_q <= fits ? diff[63:0] : partial[63:0];
          quo_q <= {quo_q[62:0], fits};
          count <= count + 7'd1;
          if (count == last) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  // Zero divisor keeps the all-ones quotient and the magnitude remainder,
  // which the sign fix turns back into the original dividend.
  always_comb begin
    q_fix     = qneg_q ? (64'd0 - quo_q) : quo_q;
    r_fix     = rneg_q ? (64'd0 - rem_q) : rem_q;
    quotient  = word_q ? sext32(q_fix[31:0]) : q_fix;
    remainder = word_q ? sext32(r_fix[31:0]) : r_fix;
    busy      = (state == DIV_BUSY);
    done      = (state == DIV_DONE);
  end

endmodule
`endif

// File: rtl/execute.sv
// Execute stage: single-cycle ALU plus optional multiply/iterative divide,
// enabled by defining MULDIV_EN.
module execute
  import execute_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  decode_data_t dataD,
  input  logic         stop_formem,
  input  logic         flushE,
  output excute_data_t dataE,
  output logic         stop_forexe,
  output logic [63:0]  rdE,
  output creg_addr_t   dstE,
  output logic         writeE,
  output logic         bubbleE
);

  logic [63:0]  a, b, alu_result, div_result;
  logic [31:0]  sum32, sub32, sll32, srl32, sra32;
  logic         div_pending, div_done;
  excute_data_t next_e;

  assign a     = dataD.srca;
  assign b     = dataD.srcb;
  assign sum32 = a[31:0] + b[31:0];
  assign sub32 = a[31:0] - b[31:0];
  assign sll32 = a[31:0] << b[4:0];
  assign srl32 = a[31:0] >> b[4:0];
  assign sra32 = $signed(a[31:0]) >>> b[4:0];

`ifdef MULDIV_EN
  logic [31:0] mul32;
  logic        div_start, div_busy, div_signed, div_word, want_rem;
  logic [63:0] quotient, remainder;

  assign mul32 = a[31:0] * b[31:0];

  // Acceptance only from IDLE, so the frozen instruction is not restarted
  assign div_start  = is_div_op(dataD.ctl.op) & ~dataD.bubble & ~stop_formem
                    & ~flushE & ~div_busy & ~div_done;
  assign div_signed = dataD.ctl.op inside {ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW};
  assign div_word   = dataD.ctl.op inside {ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
  assign want_rem   = dataD.ctl.op inside {ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW};

  divider u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .flush     (flushE),
    .hold      (stop_formem),
    .is_signed (div_signed),
    .word      (div_word),
    .a         (a),
    .b         (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign div_pending = div_start | div_busy;
  assign div_result  = want_rem ? remainder : quotient;
`else
  assign div_pending = 1'b0;
  assign div_done    = 1'b0;
  assign div_result  = '0;
`endif

  always_comb begin
    case (dataD.ctl.op)
      ALU_ADD, ALU_LD, ALU_SD: alu_result = a + b;
      ALU_SUB:   alu_result = a - b;
      ALU_AND:   alu_result = a & b;
      ALU_OR:    alu_result = a | b;
      ALU_XOR:   alu_result = a ^ b;
      ALU_SLL:   alu_result = a << b[5:0];
      ALU_SRL:   alu_result = a >> b[5:0];
      ALU_SRA:   alu_result = $signed(a) >>> b[5:0];
      ALU_SLT:   alu_result = {63'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  alu_result = {63'b0, a < b};
      ALU_LUI:   alu_result = b;
      ALU_AUIPC: alu_result = dataD.pc + b;
      ALU_JAL:   alu_result = dataD.pc + 64'd4;
      ALU_ADDW:  alu_result = sext32(sum32);
      ALU_SUBW:  alu_result = sext32(sub32);
      ALU_SLLW:  alu_result = sext32(sll32);
      ALU_SRLW:  alu_result = sext32(srl32);
      ALU_SRAW:  alu_result = sext32(sra32);
`ifdef MULDIV_EN
      ALU_MUL:   alu_result = a * b;
      ALU_MULW:  alu_result = sext32(mul32);
`endif
      default:   alu_result = '0;
    endcase
  end

  always_comb begin
    next_e            = '0;
    next_e.ctl        = dataD.ctl;
    next_e.pc         = dataD.pc;
    next_e.iresp_data = dataD.iresp_data;
    next_e.result     = div_done ? div_result : alu_result;
    next_e.rd2        = dataD.rd2;
    next_e.dst        = dataD.dst;
    next_e.bubble     = dataD.bubble | div_pending;
    next_e.valid      = dataD.valid;
    next_e.ismem      = dataD.ismem;
  end

  // Flush outranks the memory-stage stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataE <= '0;
    end else if (flushE) begin
      dataE        <= '0;
      dataE.bubble <= 1'b1;
    end else if (!stop_formem) begin
      dataE <= next_e;
    end
  end

  assign rdE         = reset ? '0 : next_e.result;
  assign dstE        = reset ? '0 : next_e.dst;
  assign writeE      = ~reset & next_e.ctl.regwrite;
  assign bubbleE     = ~reset & next_e.bubble;
  assign stop_forexe = ~reset & div_pending;

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute stage; division checks run
// when MULDIV_EN is defined, otherwise the disabled-feature behaviour is checked.
module tb_execute;
  import execute_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  decode_data_t dataD;
  logic         stop_formem, flushE;
  excute_data_t dataE;
  logic         stop_forexe;
  logic [63:0]  rdE;
  creg_addr_t   dstE;
  logic         writeE, bubbleE;

  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  execute dut (
    .clk         (clk),
    .reset       (reset),
    .dataD       (dataD),
    .stop_formem (stop_formem),
    .flushE      (flushE),
    .dataE       (dataE),
    .stop_forexe (stop_forexe),
    .rdE         (rdE),
    .dstE        (dstE),
    .writeE      (writeE),
    .bubbleE     (bubbleE)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input alu_op_t op, input logic [63:0] srca,
                               input logic [63:0] srcb, input logic bub);
    dataD              = '0;
    dataD.ctl.op       = op;
    dataD.ctl.regwrite = 1'b1;
    dataD.pc           = 64'h1000;
    dataD.iresp_data   = 32'h0000_0033;
    dataD.srca         = srca;
    dataD.srcb         = srcb;
    dataD.rd2          = 64'hDEAD_BEEF_0000_0001;
    dataD.dst          = 5'd7;
    dataD.bubble       = bub;
    dataD.valid        = ~bub;
    dataD.ismem        = (op == ALU_LD) || (op == ALU_SD);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic aluStep(input string tag, input alu_op_t op, input logic [63:0] srca,
                         input logic [63:0] srcb, input logic [63:0] expected);
    applyStimulus(op, srca, srcb, 1'b0);
    tick();
    checkOutput(tag, dataE.result, expected);
  endtask

  // Counts cycles the freeze request stays high, bounded so a stuck divider ends the run
  task automatic waitDone(input string tag, output int n);
    n = 0;
    while (stop_forexe && n < 200) begin
      n++;
      checkOutput({tag, "_busy_bubble"}, 64'(dataE.bubble), 64'd1);
      tick();
    end
  endtask

  task automatic runDiv(input string tag, input alu_op_t op, input logic [63:0] srca,
                        input logic [63:0] srcb, input logic [63:0] expected,
                        input int cycles);
    int n;
    applyStimulus(op, srca, srcb, 1'b0);
    #1;
    checkOutput({tag, "_accept_stall"}, 64'(stop_forexe), 64'd1);
    tick();
    waitDone(tag, n);
    checkOutput({tag, "_busy_cycles"}, 64'(n), 64'(cycles));
    checkOutput({tag, "_fwd"}, rdE, expected);
    tick();
    checkOutput({tag, "_result"}, dataE.result, expected);
    checkOutput({tag, "_bubble"}, 64'(dataE.bubble), 64'd0);
    applyStimulus(ALU_ADD, 64'd0, 64'd0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset       = 1'b1;
    stop_formem = 1'b0;
    flushE      = 1'b0;
    applyStimulus(ALU_ADD, 64'd0, 64'd0, 1'b1);
    #1;
    checkOutput("reset_dataE_zero", 64'(dataE == '0), 64'd1);
    checkOutput("reset_stop_forexe", 64'(stop_forexe), 64'd0);
    checkOutput("reset_writeE", 64'(writeE), 64'd0);
    checkOutput("reset_bubbleE", 64'(bubbleE), 64'd0);
    repeat (2) tick();
    reset = 1'b0;

    // ADD with forwarding seen before the edge
    applyStimulus(ALU_ADD, 64'd5, 64'd7, 1'b0);
    #1;
    checkOutput("add_fwd_rdE", rdE, 64'd12);
    checkOutput("add_fwd_dstE", 64'(dstE), 64'd7);
    checkOutput("add_fwd_writeE", 64'(writeE), 64'd1);
    checkOutput("add_stop_forexe", 64'(stop_forexe), 64'd0);
    tick();
    checkOutput("add_result", dataE.result, 64'd12);
    checkOutput("add_bubble", 64'(dataE.bubble), 64'd0);
    checkOutput("add_pc", dataE.pc, 64'h1000);
    checkOutput("add_iresp", 64'(dataE.iresp_data), 64'h33);

    aluStep("sub",   ALU_SUB,   64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    aluStep("and",   ALU_AND,   64'hF0F0, 64'hFF00, 64'hF000);
    aluStep("xor",   ALU_XOR,   64'hF0F0, 64'hFF00, 64'h0FF0);
    aluStep("sll",   ALU_SLL,   64'd1, 64'd63, 64'h8000_0000_0000_0000);
    aluStep("sra",   ALU_SRA,   64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
    aluStep("srl",   ALU_SRL,   64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000);
    aluStep("slt",   ALU_SLT,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    aluStep("sltu",  ALU_SLTU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    aluStep("addw",  ALU_ADDW,  64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
    aluStep("sraw",  ALU_SRAW,  64'h0000_0000_8000_0000, 64'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    aluStep("lui",   ALU_LUI,   64'd0, 64'h1234_5000, 64'h1234_5000);
    aluStep("auipc", ALU_AUIPC, 64'd0, 64'h2000, 64'h3000);
    aluStep("jal",   ALU_JAL,   64'd0, 64'd0, 64'h1004);
    aluStep("ld",    ALU_LD,    64'h100, 64'd8, 64'h108);
    checkOutput("ld_ismem", 64'(dataE.ismem), 64'd1);
    aluStep("sd",    ALU_SD,    64'h200, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1F8);
    checkOutput("sd_rd2", dataE.rd2, 64'hDEAD_BEEF_0000_0001);

    applyStimulus(ALU_ADD, 64'd1, 64'd1, 1'b1);
    tick();
    checkOutput("bubble_in", 64'(dataE.bubble), 64'd1);

    // Memory stall holds the register, flush overrides the stall
    aluStep("pre_stall", ALU_ADD, 64'd1, 64'd2, 64'd3);
    stop_formem = 1'b1;
    applyStimulus(ALU_ADD, 64'd10, 64'd20, 1'b0);
    repeat (2) begin
      tick();
      checkOutput("stall_hold", dataE.result, 64'd3);
    end
    stop_formem = 1'b0;
    tick();
    checkOutput("stall_release", dataE.result, 64'd30);
    stop_formem = 1'b1;
    flushE      = 1'b1;
    tick();
    checkOutput("flush_bubble", 64'(dataE.bubble), 64'd1);
    checkOutput("flush_result", dataE.result, 64'd0);
    stop_formem = 1'b0;
    flushE      = 1'b0;

`ifdef MULDIV_EN
    aluStep("mul",  ALU_MUL,  64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4);
    aluStep("mulw", ALU_MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    aluStep("mul_wrap", ALU_MUL, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0);
    applyStimulus(ALU_ADD, 64'd0, 64'd0, 1'b1);

    runDiv("div",      ALU_DIV,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 64);
    runDiv("rem",      ALU_REM,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64);
    runDiv("divu_z",   ALU_DIVU,  64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    runDiv("remu_z",   ALU_REMU,  64'd100, 64'd0, 64'd100, 64);
    runDiv("rem_z",    ALU_REM,   64'hFFFF_FFFF_FFFF_FFEC, 64'd0, 64'hFFFF_FFFF_FFFF_FFEC, 64);
    runDiv("div_ovf",  ALU_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 64);
    runDiv("rem_ovf",  ALU_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64);
    runDiv("divw",     ALU_DIVW,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 32);
    runDiv("remuw",    ALU_REMUW, 64'hFFFF_FFFF_0000_0007, 64'd2, 64'd1, 32);

    // Result parked in DONE while the memory stage stalls
    applyStimulus(ALU_DIVU, 64'd7, 64'd2, 1'b0);
    tick();
    waitDone("hold", n);
    checkOutput("hold_busy_cycles", 64'(n), 64'd64);
    stop_formem = 1'b1;
    repeat (3) begin
      tick();
      checkOutput("hold_bubble", 64'(dataE.bubble), 64'd1);
      checkOutput("hold_result", dataE.result, 64'd0);
      checkOutput("hold_stop_forexe", 64'(stop_forexe), 64'd0);
      checkOutput("hold_fwd", rdE, 64'd3);
    end
    stop_formem = 1'b0;
    tick();
    checkOutput("hold_release_result", dataE.result, 64'd3);
    checkOutput("hold_release_bubble", 64'(dataE.bubble), 64'd0);
    applyStimulus(ALU_ADD, 64'd0, 64'd0, 1'b1);

    // Flush in the tenth busy cycle
    applyStimulus(ALU_DIV, 64'd1000, 64'd7, 1'b0);
    tick();
    repeat (9) tick();
    checkOutput("flushdiv_busy", 64'(stop_forexe), 64'd1);
    flushE = 1'b1;
    tick();
    checkOutput("flushdiv_bubble", 64'(dataE.bubble), 64'd1);
    checkOutput("flushdiv_stop", 64'(stop_forexe), 64'd0);
    flushE = 1'b0;
    applyStimulus(ALU_ADD, 64'd2, 64'd3, 1'b0);
    #1;
    checkOutput("flushdiv_idle", 64'(stop_forexe), 64'd0);
    tick();
    checkOutput("flushdiv_next", dataE.result, 64'd5);

    // Asynchronous reset in the middle of a division
    applyStimulus(ALU_DIV, 64'd1000, 64'd7, 1'b0);
    tick();
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstdiv_dataE_zero", 64'(dataE == '0), 64'd1);
    checkOutput("rstdiv_stop_forexe", 64'(stop_forexe), 64'd0);
    checkOutput("rstdiv_writeE", 64'(writeE), 64'd0);
    checkOutput("rstdiv_bubbleE", 64'(bubbleE), 64'd0);
    applyStimulus(ALU_ADD, 64'd0, 64'd0, 1'b1);
    tick();
    reset = 1'b0;
    applyStimulus(ALU_ADD, 64'd4, 64'd4, 1'b0);
    #1;
    checkOutput("rstdiv_idle", 64'(stop_forexe), 64'd0);
    tick();
    checkOutput("rstdiv_next", dataE.result, 64'd8);
`else
    aluStep("mul_off", ALU_MUL, 64'd3, 64'd4, 64'd0);
    applyStimulus(ALU_DIV, 64'd20, 64'd3, 1'b0);
    #1;
    checkOutput("div_off_stop", 64'(stop_forexe), 64'd0);
    tick();
    checkOutput("div_off_result", dataE.result, 64'd0);
    checkOutput("div_off_bubble", 64'(dataE.bubble), 64'd0);

    aluStep("pre_rst", ALU_ADD, 64'd1, 64'd1, 64'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_zero", 64'(dataE == '0), 64'd1);
    checkOutput("rst_async_writeE", 64'(writeE), 64'd0);
    tick();
    reset = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
